// File: rtl/bullet_pkg.sv
// bullet_pkg: shared screen constants, channel states and hitbox
// defaults for the bullet tracker, plus the 1-D overlap helper.
package bullet_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int COORD_W  = 10;

  localparam int DEF_NUM_ENEMIES = 8;
  localparam int DEF_SPAWN_Y     = 440;
  localparam int DEF_SPAWN_X_OFF = 7;
  localparam int DEF_SPEED       = 4;
  localparam int DEF_BULLET_W    = 2;
  localparam int DEF_BULLET_H    = 6;
  localparam int DEF_ENEMY_W     = 16;
  localparam int DEF_ENEMY_H     = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFlying = 2'd1,
    StDone   = 2'd2
  } bullet_ch_state_e;

  // Interval overlap on one axis, one bit wider than a
  // coordinate so edge + size never wraps.
  function automatic logic ovl_1d(
    input logic [COORD_W:0] a,
    input logic [COORD_W:0] a_len,
    input logic [COORD_W:0] b,
    input logic [COORD_W:0] b_len
  );
    return (a < b + b_len) && (b < a + a_len);
  endfunction

endpackage

// File: rtl/bullet_tracker_channel.sv
// bullet_channel: one bullet. Edge-detects bdisplay, spawns,
// moves on frame ticks, searches enemies for overlap, and holds
// the done level until the display FSM drops bdisplay.
// Ports: clk_i/reset_ni, frame_tick_i, ship_x_i, bdisplay_i,
// enemy_x_i/enemy_y_i/enemy_alive_i, grant_i in;
// hit_req_o/hit_idx_o, bhit_o, x_o/y_o out.
module bullet_channel
  import bullet_pkg::*;
#(
  parameter int NUM_ENEMIES = DEF_NUM_ENEMIES,
  parameter int IDX_W       = $clog2(DEF_NUM_ENEMIES),
  parameter int SPAWN_Y     = DEF_SPAWN_Y,
  parameter int SPAWN_X_OFF = DEF_SPAWN_X_OFF,
  parameter int SPEED       = DEF_SPEED,
  parameter int BULLET_W    = DEF_BULLET_W,
  parameter int BULLET_H    = DEF_BULLET_H,
  parameter int ENEMY_W     = DEF_ENEMY_W,
  parameter int ENEMY_H     = DEF_ENEMY_H
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 frame_tick_i,
  input  logic [COORD_W-1:0]   ship_x_i,
  input  logic                 bdisplay_i,
  input  logic [NUM_ENEMIES-1:0][COORD_W-1:0] enemy_x_i,
  input  logic [NUM_ENEMIES-1:0][COORD_W-1:0] enemy_y_i,
  input  logic [NUM_ENEMIES-1:0] enemy_alive_i,
  input  logic                 grant_i,
  output logic                 hit_req_o,
  output logic [IDX_W-1:0]     hit_idx_o,
  output logic                 bhit_o,
  output logic [COORD_W-1:0]   x_o,
  output logic [COORD_W-1:0]   y_o
);

  localparam logic [COORD_W-1:0] SpawnY =
    SPAWN_Y[COORD_W-1:0];
  localparam logic [COORD_W-1:0] XOff =
    SPAWN_X_OFF[COORD_W-1:0];
  localparam logic [COORD_W-1:0] Spd =
    SPEED[COORD_W-1:0];
  localparam logic [COORD_W:0] BW = BULLET_W[COORD_W:0];
  localparam logic [COORD_W:0] BH = BULLET_H[COORD_W:0];
  localparam logic [COORD_W:0] EW = ENEMY_W[COORD_W:0];
  localparam logic [COORD_W:0] EH = ENEMY_H[COORD_W:0];

  bullet_ch_state_e r_state;
  bullet_ch_state_e w_next;

  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic               r_prev;
  logic               w_rise;
  logic               w_exit;
  logic               w_fly;
  logic [NUM_ENEMIES-1:0] w_ovl;
  logic [IDX_W-1:0]   w_idx;

  assign w_rise = bdisplay_i & ~r_prev;
  assign w_fly  = (r_state == StFlying) & bdisplay_i;
  assign w_exit = frame_tick_i & (r_y < Spd);

  always_comb begin
    w_ovl = '0;
    for (int e = 0; e < NUM_ENEMIES; e++) begin
      w_ovl[e] = enemy_alive_i[e]
        && ovl_1d({1'b0, r_x}, BW,
                  {1'b0, enemy_x_i[e]}, EW)
        && ovl_1d({1'b0, r_y}, BH,
                  {1'b0, enemy_y_i[e]}, EH);
    end
  end

  // Lowest-index overlapping enemy wins.
  always_comb begin
    w_idx = '0;
    for (int e = NUM_ENEMIES - 1; e >= 0; e--) begin
      if (w_ovl[e]) w_idx = IDX_W'(e);
    end
  end

  assign hit_req_o = w_fly & (|w_ovl);
  assign hit_idx_o = w_idx;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) r_state <= StIdle;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_rise) w_next = StFlying;
      end
      StFlying: begin
        if (!bdisplay_i)  w_next = StIdle;
        else if (grant_i) w_next = StDone;
        else if (w_exit)  w_next = StDone;
      end
      StDone: begin
        if (!bdisplay_i) w_next = StIdle;
      end
      default: w_next = StIdle;
    endcase
  end

  always_comb begin
    bhit_o = (r_state == StDone);
  end

  // A bullet that lost arbitration still moves on a tick;
  // only a granted hit freezes it.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_x    <= '0;
      r_y    <= '0;
      r_prev <= 1'b0;
    end else begin
      r_prev <= bdisplay_i;
      if (r_state == StIdle && w_rise) begin
        r_x <= ship_x_i + XOff;
        r_y <= SpawnY;
      end else if (w_fly && !grant_i
                   && frame_tick_i && !w_exit) begin
        r_y <= r_y - Spd;
      end
    end
  end

  assign x_o = r_x;
  assign y_o = r_y;

endmodule

// File: rtl/bullet_tracker.sv
// bullet_tracker: two bullet channels plus kill arbitration.
// Ports: clk_i/reset_ni, frame_tick_i, ship_x_i, bdisplay_i,
// enemy_* in; bhit_o, bullet_x_o/y_o, kill_o/kill_idx_o out.
module bullet_tracker
  import bullet_pkg::*;
#(
  parameter int NUM_ENEMIES = DEF_NUM_ENEMIES,
  parameter int SPAWN_Y     = DEF_SPAWN_Y,
  parameter int SPAWN_X_OFF = DEF_SPAWN_X_OFF,
  parameter int SPEED       = DEF_SPEED,
  parameter int BULLET_W    = DEF_BULLET_W,
  parameter int BULLET_H    = DEF_BULLET_H,
  parameter int ENEMY_W     = DEF_ENEMY_W,
  parameter int ENEMY_H     = DEF_ENEMY_H
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 frame_tick_i,
  input  logic [COORD_W-1:0]   ship_x_i,
  input  logic [1:0]           bdisplay_i,
  input  logic [NUM_ENEMIES-1:0][COORD_W-1:0] enemy_x_i,
  input  logic [NUM_ENEMIES-1:0][COORD_W-1:0] enemy_y_i,
  input  logic [NUM_ENEMIES-1:0] enemy_alive_i,
  output logic [1:0]           bhit_o,
  output logic [1:0][COORD_W-1:0] bullet_x_o,
  output logic [1:0][COORD_W-1:0] bullet_y_o,
  output logic                 kill_o,
  output logic [$clog2(NUM_ENEMIES)-1:0] kill_idx_o
);

  localparam int IDX_W = $clog2(NUM_ENEMIES);

  logic [1:0]             w_req;
  logic [1:0][IDX_W-1:0]  w_idx;
  logic [1:0]             w_grant;
  logic [NUM_ENEMIES-1:0] w_alive;
  logic                   r_kill;
  logic [IDX_W-1:0]       r_kill_idx;

  // The formation may take a cycle to clear a killed enemy;
  // hide it meanwhile so it cannot be killed twice.
  always_comb begin
    w_alive = enemy_alive_i;
    if (r_kill) w_alive[r_kill_idx] = 1'b0;
  end

  assign w_grant[0] = w_req[0];
  assign w_grant[1] = w_req[1] & ~w_req[0];

  for (genvar g = 0; g < 2; g++) begin : g_ch
    bullet_channel #(
      .NUM_ENEMIES (NUM_ENEMIES),
      .IDX_W       (IDX_W),
      .SPAWN_Y     (SPAWN_Y),
      .SPAWN_X_OFF (SPAWN_X_OFF),
      .SPEED       (SPEED),
      .BULLET_W    (BULLET_W),
      .BULLET_H    (BULLET_H),
      .ENEMY_W     (ENEMY_W),
      .ENEMY_H     (ENEMY_H)
    ) u_ch (
      .clk_i         (clk_i),
      .reset_ni      (reset_ni),
      .frame_tick_i  (frame_tick_i),
      .ship_x_i      (ship_x_i),
      .bdisplay_i    (bdisplay_i[g]),
      .enemy_x_i     (enemy_x_i),
      .enemy_y_i     (enemy_y_i),
      .enemy_alive_i (w_alive),
      .grant_i       (w_grant[g]),
      .hit_req_o     (w_req[g]),
      .hit_idx_o     (w_idx[g]),
      .bhit_o        (bhit_o[g]),
      .x_o           (bullet_x_o[g]),
      .y_o           (bullet_y_o[g])
    );
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_kill     <= 1'b0;
      r_kill_idx <= '0;
    end else begin
      r_kill <= |w_grant;
      unique case (1'b1)
        w_grant[0]: r_kill_idx <= w_idx[0];
        w_grant[1]: r_kill_idx <= w_idx[1];
        default:    r_kill_idx <= r_kill_idx;
      endcase
    end
  end

  assign kill_o     = r_kill;
  assign kill_idx_o = r_kill_idx;

endmodule

// File: tb/tb_bullet_tracker.sv
// tb_bullet_tracker: directed scenarios with literal expectations
// followed by random play checked against a behavioural model.
module tb_bullet_tracker;

  localparam int NE = 8;

  logic clk = 1'b0;
  logic reset_ni = 1'b1;
  logic frame_tick_i = 1'b0;
  logic [9:0] ship_x_i = '0;
  logic [1:0] bdisplay_i = '0;
  logic [NE-1:0][9:0] enemy_x_i = '0;
  logic [NE-1:0][9:0] enemy_y_i = '0;
  logic [NE-1:0] enemy_alive_i = '0;
  logic [1:0] bhit_o;
  logic [1:0][9:0] bullet_x_o;
  logic [1:0][9:0] bullet_y_o;
  logic kill_o;
  logic [2:0] kill_idx_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bullet_tracker dut (
    .clk_i         (clk),
    .reset_ni      (reset_ni),
    .frame_tick_i  (frame_tick_i),
    .ship_x_i      (ship_x_i),
    .bdisplay_i    (bdisplay_i),
    .enemy_x_i     (enemy_x_i),
    .enemy_y_i     (enemy_y_i),
    .enemy_alive_i (enemy_alive_i),
    .bhit_o        (bhit_o),
    .bullet_x_o    (bullet_x_o),
    .bullet_y_o    (bullet_y_o),
    .kill_o        (kill_o),
    .kill_idx_o    (kill_idx_o)
  );

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d",
               nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 flying, 2 done
  int m_mode[2] = '{0, 0};
  int m_x[2] = '{0, 0};
  int m_y[2] = '{0, 0};
  bit m_prev[2] = '{0, 0};
  bit m_kill = 0;
  int m_kidx = 0;
  bit av[NE];
  bit req[2];
  int hidx[2];
  bit gnt[2];

  function automatic bit touches(input int bx, input int by,
                                 input int ex, input int ey);
    return bx < ex + 16 && ex < bx + 2 &&
           by < ey + 16 && ey < by + 6;
  endfunction

  always @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int b = 0; b < 2; b++) begin
        m_mode[b] = 0; m_x[b] = 0; m_y[b] = 0;
        m_prev[b] = 0;
      end
      m_kill = 0; m_kidx = 0;
    end else begin
      for (int e = 0; e < NE; e++)
        av[e] = enemy_alive_i[e] && !(m_kill && m_kidx == e);
      for (int b = 0; b < 2; b++) begin
        req[b] = 0; hidx[b] = 0;
        if (m_mode[b] == 1 && bdisplay_i[b]) begin
          for (int e = NE - 1; e >= 0; e--)
            if (av[e] && touches(m_x[b], m_y[b],
                int'(enemy_x_i[e]), int'(enemy_y_i[e]))) begin
              req[b] = 1; hidx[b] = e;
            end
        end
      end
      gnt[0] = req[0];
      gnt[1] = req[1] && !req[0];
      m_kill = gnt[0] || gnt[1];
      if (gnt[0]) m_kidx = hidx[0];
      else if (gnt[1]) m_kidx = hidx[1];
      for (int b = 0; b < 2; b++) begin
        bit rise;
        rise = bdisplay_i[b] && !m_prev[b];
        m_prev[b] = bdisplay_i[b];
        case (m_mode[b])
          0: if (rise) begin
            m_mode[b] = 1;
            m_x[b] = (int'(ship_x_i) + 7) % 1024;
            m_y[b] = 440;
          end
          1: begin
            if (!bdisplay_i[b]) m_mode[b] = 0;
            else if (gnt[b]) m_mode[b] = 2;
            else if (frame_tick_i) begin
              if (m_y[b] < 4) m_mode[b] = 2;
              else m_y[b] = m_y[b] - 4;
            end
          end
          default: if (!bdisplay_i[b]) m_mode[b] = 0;
        endcase
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    for (int b = 0; b < 2; b++) begin
      chk($sformatf("bhit%0d", b), int'(bhit_o[b]),
          int'(m_mode[b] == 2));
      chk($sformatf("x%0d", b), int'(bullet_x_o[b]), m_x[b]);
      chk($sformatf("y%0d", b), int'(bullet_y_o[b]), m_y[b]);
    end
    chk("kill", int'(kill_o), int'(m_kill));
    if (m_kill) chk("kill_idx", int'(kill_idx_o), m_kidx);
  end

  // ---------------- stimulus ----------------
  bit pend = 0;
  int pidx = 0;

  // Ends at negedge+1; formation clears a killed enemy
  // one cycle after the kill pulse.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
    if (pend) enemy_alive_i[pidx] = 1'b0;
    pend = m_kill;
    pidx = m_kidx;
  endtask

  task automatic tick();
    frame_tick_i = 1'b1;
    cyc();
    frame_tick_i = 1'b0;
    cyc();
  endtask

  int base;

  initial begin
    #1 reset_ni = 1'b0;
    #2;
    chk("rst_bhit", int'(bhit_o), 0);
    chk("rst_x0", int'(bullet_x_o[0]), 0);
    chk("rst_y1", int'(bullet_y_o[1]), 0);
    chk("rst_kill", int'(kill_o), 0);
    repeat (2) @(negedge clk);
    #1 reset_ni = 1'b1;

    // spawn
    ship_x_i = 10'd100;
    bdisplay_i = 2'b01;
    cyc();
    chk("spawn_x", int'(bullet_x_o[0]), 107);
    chk("spawn_y", int'(bullet_y_o[0]), 440);
    chk("spawn_bhit", int'(bhit_o), 0);

    // top exit, no enemies
    repeat (110) tick();
    chk("exit_y0", int'(bullet_y_o[0]), 0);
    chk("exit_pre_bhit", int'(bhit_o[0]), 0);
    tick();
    chk("exit_bhit", int'(bhit_o[0]), 1);
    chk("exit_y_hold", int'(bullet_y_o[0]), 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("held_bhit", int'(bhit_o[0]), 1);
    end
    bdisplay_i[0] = 1'b0;
    cyc();
    chk("drop_bhit", int'(bhit_o[0]), 0);
    bdisplay_i[0] = 1'b1;
    cyc();
    chk("respawn_y", int'(bullet_y_o[0]), 440);
    chk("respawn_x", int'(bullet_x_o[0]), 107);

    // collision with enemy 0 at (100,400)
    enemy_x_i[0] = 10'd100;
    enemy_y_i[0] = 10'd400;
    enemy_alive_i = 8'h01;
    repeat (6) tick();
    chk("col_y6", int'(bullet_y_o[0]), 416);
    chk("col_nohit", int'(bhit_o[0]), 0);
    tick();
    chk("col_y7", int'(bullet_y_o[0]), 412);
    chk("col_kill", int'(kill_o), 1);
    chk("col_idx", int'(kill_idx_o), 0);
    chk("col_bhit", int'(bhit_o[0]), 1);
    cyc();
    chk("col_kill_once", int'(kill_o), 0);
    bdisplay_i[0] = 1'b0;
    cyc();

    // both bullets on enemy 3, enemy 4 further up
    enemy_alive_i = '0;
    enemy_x_i[3] = 10'd100; enemy_y_i[3] = 10'd400;
    enemy_x_i[4] = 10'd100; enemy_y_i[4] = 10'd300;
    enemy_alive_i[3] = 1'b1;
    enemy_alive_i[4] = 1'b1;
    bdisplay_i = 2'b11;
    cyc();
    repeat (7) tick();
    chk("sim_kill", int'(kill_o), 1);
    chk("sim_idx", int'(kill_idx_o), 3);
    chk("sim_bhit", int'(bhit_o), 1);
    cyc();
    chk("sim_one_kill", int'(kill_o), 0);
    chk("sim_b1_fly", int'(bhit_o[1]), 0);
    repeat (25) tick();
    chk("sim_y1", int'(bullet_y_o[1]), 312);
    chk("sim2_kill", int'(kill_o), 1);
    chk("sim2_idx", int'(kill_idx_o), 4);
    chk("sim2_bhit", int'(bhit_o), 3);
    repeat (3) cyc();
    chk("sim_b1_held", int'(bhit_o[1]), 1);
    bdisplay_i[1] = 1'b0;
    cyc();
    chk("sim_b1_drop", int'(bhit_o), 1);
    bdisplay_i[0] = 1'b0;
    cyc();

    // async reset mid-flight
    enemy_alive_i = '0;
    ship_x_i = 10'd200;
    bdisplay_i[0] = 1'b1;
    cyc();
    repeat (60) tick();
    chk("mid_y", int'(bullet_y_o[0]), 200);
    #2 reset_ni = 1'b0;
    #1;
    chk("mid_rst_y", int'(bullet_y_o[0]), 0);
    chk("mid_rst_x", int'(bullet_x_o[0]), 0);
    chk("mid_rst_bhit", int'(bhit_o), 0);
    @(posedge clk);
    #2 reset_ni = 1'b1;
    cyc();
    chk("mid_respawn_y", int'(bullet_y_o[0]), 440);
    chk("mid_respawn_x", int'(bullet_x_o[0]), 207);

    // random play
    base = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 64 == 0) begin
        base = int'($urandom_range(0, 1023));
        for (int e = 0; e < NE; e++) begin
          enemy_x_i[e] = 10'((base + 1004 +
            int'($urandom_range(0, 40))) % 1024);
          enemy_y_i[e] = 10'($urandom_range(0, 460));
        end
        enemy_alive_i = 8'($urandom);
      end
      ship_x_i = 10'((base + int'($urandom_range(0, 8)))
                     % 1024);
      frame_tick_i = ($urandom_range(0, 2) == 0);
      for (int b = 0; b < 2; b++) begin
        if (m_mode[b] == 2)
          bdisplay_i[b] = ($urandom_range(0, 2) != 0);
        else if (!bdisplay_i[b])
          bdisplay_i[b] = ($urandom_range(0, 3) == 0);
        else if (m_mode[b] == 1 &&
                 $urandom_range(0, 99) == 0)
          bdisplay_i[b] = 1'b0;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
